// File: rtl/frame_rotator_pkg.sv
// Shared types and constants for frame_rotator: FSM states, CORDIC arctangent table, gain and angle constants.
package frame_rotator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REDUCE,
      ST_ROTATE,
      ST_SCALE,
      ST_DONE
   } state_e;

   localparam int unsigned ATAN_Q     = 30;
   localparam int unsigned ATAN_DEPTH = 24;

   // 1/prod(sqrt(1+2^-2i)) = 0.6072529 in Q30
   localparam logic [63:0] CORDIC_K_Q30 = 64'd652032837;

   // atan(2^-i) in degrees, Q30
   function automatic logic [63:0] atan_deg_q30(input logic [4:0] idx);
      case (idx)
         5'd0:    return 64'd48318382080;
         5'd1:    return 64'd28524006502;
         5'd2:    return 64'd15071301663;
         5'd3:    return 64'd7650428051;
         5'd4:    return 64'd3840059795;
         5'd5:    return 64'd1921901881;
         5'd6:    return 64'd961185452;
         5'd7:    return 64'd480622057;
         5'd8:    return 64'd240314695;
         5'd9:    return 64'd120157806;
         5'd10:   return 64'd60078960;
         5'd11:   return 64'd30039488;
         5'd12:   return 64'd15019744;
         5'd13:   return 64'd7509873;
         5'd14:   return 64'd3754936;
         5'd15:   return 64'd1877468;
         5'd16:   return 64'd938734;
         5'd17:   return 64'd469367;
         5'd18:   return 64'd234684;
         5'd19:   return 64'd117342;
         5'd20:   return 64'd58671;
         5'd21:   return 64'd29335;
         5'd22:   return 64'd14668;
         5'd23:   return 64'd7334;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] atan_deg(input logic [4:0] idx, input int unsigned q);
      return atan_deg_q30(idx) >> (ATAN_Q - q);
   endfunction

   function automatic logic [63:0] cordic_k(input int unsigned q);
      return CORDIC_K_Q30 >> (ATAN_Q - q);
   endfunction

   function automatic logic [63:0] angle_deg(input int unsigned deg, input int unsigned q);
      return 64'(deg) << q;
   endfunction

endpackage

// File: rtl/frame_rotator_if.sv
// Request/result bundle of frame_rotator; master issues rotations, slave is the rotator.
interface frame_rotator_if #(
   parameter int unsigned N_WIDTH = 32
);
   logic               FRAME_ROTATOR_READY_In;
   logic               FRAME_ROTATOR_MODE_In;
   logic [N_WIDTH-1:0] FRAME_ROTATOR_VX_InBus;
   logic [N_WIDTH-1:0] FRAME_ROTATOR_VY_InBus;
   logic [N_WIDTH-1:0] FRAME_ROTATOR_WZ_InBus;
   logic [N_WIDTH-1:0] FRAME_ROTATOR_THETA_InBus;
   logic               FRAME_ROTATOR_BUSY_Out;
   logic               FRAME_ROTATOR_DONE_Out;
   logic [N_WIDTH-1:0] FRAME_ROTATOR_VX_OutBus;
   logic [N_WIDTH-1:0] FRAME_ROTATOR_VY_OutBus;
   logic [N_WIDTH-1:0] FRAME_ROTATOR_WZ_OutBus;

   modport master (
      output FRAME_ROTATOR_READY_In, FRAME_ROTATOR_MODE_In, FRAME_ROTATOR_VX_InBus,
             FRAME_ROTATOR_VY_InBus, FRAME_ROTATOR_WZ_InBus, FRAME_ROTATOR_THETA_InBus,
      input  FRAME_ROTATOR_BUSY_Out, FRAME_ROTATOR_DONE_Out, FRAME_ROTATOR_VX_OutBus,
             FRAME_ROTATOR_VY_OutBus, FRAME_ROTATOR_WZ_OutBus
   );

   modport slave (
      input  FRAME_ROTATOR_READY_In, FRAME_ROTATOR_MODE_In, FRAME_ROTATOR_VX_InBus,
             FRAME_ROTATOR_VY_InBus, FRAME_ROTATOR_WZ_InBus, FRAME_ROTATOR_THETA_InBus,
      output FRAME_ROTATOR_BUSY_Out, FRAME_ROTATOR_DONE_Out, FRAME_ROTATOR_VX_OutBus,
             FRAME_ROTATOR_VY_OutBus, FRAME_ROTATOR_WZ_OutBus
   );
endinterface

// File: rtl/frame_rotator_cordic_core.sv
// Iterative rotation-mode CORDIC: x/y/z registers, one micro-rotation per step, iteration counter.
module frame_rotator_cordic_core
   import frame_rotator_pkg::*;
#(
   parameter int unsigned N_WIDTH = 32,
   parameter int unsigned Q_WIDTH = 15,
   parameter int unsigned ITER_M  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load,
   input  logic                      step,
   input  logic signed [N_WIDTH+1:0] x_in,
   input  logic signed [N_WIDTH+1:0] y_in,
   input  logic signed [N_WIDTH+1:0] z_in,
   output logic signed [N_WIDTH+1:0] x_o,
   output logic signed [N_WIDTH+1:0] y_o,
   output logic                      last_c
);
   localparam int unsigned W  = N_WIDTH + 2;
   localparam int unsigned CW = $clog2(ITER_M + 1);

   logic signed [W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [W-1:0]  x_sh_c, y_sh_c, atan_c;
   logic        [CW-1:0] iter_q, iter_d;

   assign last_c = (iter_q == CW'(ITER_M - 1));
   assign x_o    = x_q;
   assign y_o    = y_q;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      z_d    = z_q;
      iter_d = iter_q;
      x_sh_c = x_q >>> iter_q;
      y_sh_c = y_q >>> iter_q;
      atan_c = W'(atan_deg(5'(iter_q), Q_WIDTH));
      if (load) begin
         x_d    = x_in;
         y_d    = y_in;
         z_d    = z_in;
         iter_d = '0;
      end else if (step) begin
         // drive residual angle toward zero; d = +1 when z >= 0
         if (!z_q[W-1]) begin
            x_d = x_q - y_sh_c;
            y_d = y_q + x_sh_c;
            z_d = z_q - atan_c;
         end else begin
            x_d = x_q + y_sh_c;
            y_d = y_q - x_sh_c;
            z_d = z_q + atan_c;
         end
         iter_d = last_c ? '0 : iter_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
         iter_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         z_q    <= z_d;
         iter_q <= iter_d;
      end
   end

endmodule

// File: rtl/frame_rotator.sv
// 2-D velocity frame rotator (CORDIC). FSM, quadrant reduction, gain scaling, output registers.
// FRAME_ROTATOR_SATURATE_EN: clamp scaled results to the N-bit range instead of wrapping.
module frame_rotator
   import frame_rotator_pkg::*;
#(
   parameter int unsigned N_WIDTH = 32,
   parameter int unsigned Q_WIDTH = 15,
   parameter int unsigned ITER_M  = 16
) (
   input  logic           FRAME_ROTATOR_CLOCK_50,
   input  logic           FRAME_ROTATOR_RESET_InLow,
   frame_rotator_if.slave bus
);
   localparam int unsigned W  = N_WIDTH + 2;
   localparam int unsigned KW = Q_WIDTH + 2;
   localparam int unsigned PW = W + KW;

   localparam logic signed [W-1:0]  A90   = W'(angle_deg(90, Q_WIDTH));
   localparam logic signed [W-1:0]  A180  = W'(angle_deg(180, Q_WIDTH));
   localparam logic signed [W-1:0]  A360  = W'(angle_deg(360, Q_WIDTH));
   localparam logic signed [KW-1:0] K_S   = KW'(cordic_k(Q_WIDTH));
   localparam logic [N_WIDTH-1:0]   O_MAX = {1'b0, {(N_WIDTH-1){1'b1}}};
   localparam logic [N_WIDTH-1:0]   O_MIN = {1'b1, {(N_WIDTH-1){1'b0}}};

   state_e               state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d, mode_q, mode_d;
   logic [N_WIDTH-1:0]   vx_cap_q, vx_cap_d, vy_cap_q, vy_cap_d, wz_cap_q, wz_cap_d;
   logic [N_WIDTH-1:0]   theta_q, theta_d;
   logic [N_WIDTH-1:0]   vx_out_q, vx_out_d, vy_out_q, vy_out_d, wz_out_q, wz_out_d;
   logic signed [W-1:0]  t_c, x_red_c, y_red_c, core_x, core_y;
   logic signed [PW-1:0] px_c, py_c;
   logic                 core_last_c, load_c, step_c;

   function automatic logic [N_WIDTH-1:0] scale_out(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] sh;
      sh = p >>> Q_WIDTH;
`ifdef FRAME_ROTATOR_SATURATE_EN
      if (sh[PW-1:N_WIDTH-1] != {(PW-N_WIDTH+1){sh[PW-1]}})
         return sh[PW-1] ? O_MIN : O_MAX;
`endif
      return N_WIDTH'(sh);
   endfunction

   // fold heading into [-90,+90], pre-rotating the vector by 180 deg when needed
   always_comb begin
      t_c     = W'($signed(theta_q));
      x_red_c = W'($signed(vx_cap_q));
      y_red_c = W'($signed(vy_cap_q));
      if (mode_q) t_c = -t_c;
      if (t_c < -A180)      t_c = t_c + A360;
      else if (t_c >= A180) t_c = t_c - A360;
      if (t_c > A90) begin
         t_c     = t_c - A180;
         x_red_c = -x_red_c;
         y_red_c = -y_red_c;
      end else if (t_c < -A90) begin
         t_c     = t_c + A180;
         x_red_c = -x_red_c;
         y_red_c = -y_red_c;
      end
   end

   assign load_c = (state_q == ST_REDUCE);
   assign step_c = (state_q == ST_ROTATE);
   assign px_c   = PW'(core_x) * PW'(K_S);
   assign py_c   = PW'(core_y) * PW'(K_S);

   frame_rotator_cordic_core #(
      .N_WIDTH (N_WIDTH),
      .Q_WIDTH (Q_WIDTH),
      .ITER_M  (ITER_M)
   ) u_core (
      .clk    (FRAME_ROTATOR_CLOCK_50),
      .rst_n  (FRAME_ROTATOR_RESET_InLow),
      .load   (load_c),
      .step   (step_c),
      .x_in   (x_red_c),
      .y_in   (y_red_c),
      .z_in   (t_c),
      .x_o    (core_x),
      .y_o    (core_y),
      .last_c (core_last_c)
   );

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      mode_d   = mode_q;
      vx_cap_d = vx_cap_q;
      vy_cap_d = vy_cap_q;
      wz_cap_d = wz_cap_q;
      theta_d  = theta_q;
      vx_out_d = vx_out_q;
      vy_out_d = vy_out_q;
      wz_out_d = wz_out_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.FRAME_ROTATOR_READY_In) begin
               mode_d   = bus.FRAME_ROTATOR_MODE_In;
               vx_cap_d = bus.FRAME_ROTATOR_VX_InBus;
               vy_cap_d = bus.FRAME_ROTATOR_VY_InBus;
               wz_cap_d = bus.FRAME_ROTATOR_WZ_InBus;
               theta_d  = bus.FRAME_ROTATOR_THETA_InBus;
               busy_d   = 1'b1;
               state_d  = ST_REDUCE;
            end
         end
         ST_REDUCE: state_d = ST_ROTATE;
         ST_ROTATE: if (core_last_c) state_d = ST_SCALE;
         ST_SCALE: begin
            vx_out_d = scale_out(px_c);
            vy_out_d = scale_out(py_c);
            wz_out_d = wz_cap_q;
            done_d   = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge FRAME_ROTATOR_CLOCK_50) begin
      if (!FRAME_ROTATOR_RESET_InLow) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         mode_q   <= 1'b0;
         vx_cap_q <= '0;
         vy_cap_q <= '0;
         wz_cap_q <= '0;
         theta_q  <= '0;
         vx_out_q <= '0;
         vy_out_q <= '0;
         wz_out_q <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         mode_q   <= mode_d;
         vx_cap_q <= vx_cap_d;
         vy_cap_q <= vy_cap_d;
         wz_cap_q <= wz_cap_d;
         theta_q  <= theta_d;
         vx_out_q <= vx_out_d;
         vy_out_q <= vy_out_d;
         wz_out_q <= wz_out_d;
      end
   end

   assign bus.FRAME_ROTATOR_BUSY_Out  = busy_q;
   assign bus.FRAME_ROTATOR_DONE_Out  = done_q;
   assign bus.FRAME_ROTATOR_VX_OutBus = vx_out_q;
   assign bus.FRAME_ROTATOR_VY_OutBus = vy_out_q;
   assign bus.FRAME_ROTATOR_WZ_OutBus = wz_out_q;

endmodule
